// File: rtl/vend_pkg.sv
// Shared vending encodings: one-hot FSM states, drink codes and coin types.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vend_pkg;

    typedef logic [4:0] state_t;

    localparam state_t ST_IDLE     = 5'b00001;
    localparam state_t ST_DRINK    = 5'b00010;
    localparam state_t ST_GAP      = 5'b00100;
    localparam state_t ST_COIN_REQ = 5'b01000;
    localparam state_t ST_DONE     = 5'b10000;

    localparam logic [1:0] DRK_NONE = 2'd0;
    localparam logic [1:0] DRK_5    = 2'd1;
    localparam logic [1:0] DRK_10   = 2'd2;

    localparam logic COIN5  = 1'b0;
    localparam logic COIN10 = 1'b1;

    // Code 3 is reserved and behaves like DRK_NONE.
    function automatic logic is_drink(input logic [1:0] sel);
        return (sel == DRK_5) || (sel == DRK_10);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter that saturates at zero and flags it.
// Latency: load takes effect next cycle; zero is combinational from the count.
// Backpressure: none; counts every cycle it is not being loaded.
module vend_pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense controller: PULSE_W-cycle drink strobe, then tens-first coin payout over req/ack.
// Latency: req -> drink_out 1 cycle; drink-only req -> done after PULSE_W + 1 further cycles.
// Backpressure: COIN_REQ holds until coin_ack; req ignored while busy. VEND_DISPENSE_TIMEOUT_EN adds hopper timeout.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int CHG_W       = 3,
    parameter int PULSE_W     = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [1:0]       drink_sel,
    input  logic [CHG_W-1:0] change_amt,
    output logic             busy,
    output logic [1:0]       drink_out,
    output logic             coin_req,
    output logic             coin_type,
    input  logic             coin_ack,
    output logic             done,
    output logic             err
);

    localparam int N10_W   = CHG_W - 1;
    localparam int TMR_MAX = max_int(max_int(PULSE_W, GAP_CYC), TIMEOUT_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t            state_q;
    state_t            state_nx;
    logic [1:0]        sel_q;
    logic [N10_W-1:0]  n10_q;
    logic              n5_q;
    logic              accept;
    logic              coin_taken;
    logic              coins_left;
    logic              last_coin;
    logic              tmr_load;
    logic              tmr_zero;
    logic [TMR_W-1:0]  tmr_val;

    assign accept     = (state_q == ST_IDLE) && req;
    assign coin_taken = (state_q == ST_COIN_REQ) && coin_ack;
    assign coins_left = (n10_q != '0) || n5_q;
    // Valid only in COIN_REQ: true when the coin being paid is the final one.
    assign last_coin  = (n10_q != '0) ? ((n10_q == N10_W'(1)) && !n5_q) : 1'b1;

`ifdef VEND_DISPENSE_TIMEOUT_EN
    logic timed_out;
    logic err_q;

    assign timed_out = (state_q == ST_COIN_REQ) && !coin_ack && tmr_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (is_drink(drink_sel)) begin
                        state_nx = ST_DRINK;
                    end else if (change_amt != '0) begin
                        state_nx = ST_GAP;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DRINK: begin
                if (tmr_zero) begin
                    state_nx = coins_left ? ST_GAP : ST_DONE;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_nx = ST_COIN_REQ;
                end
            end
            ST_COIN_REQ: begin
                if (coin_ack) begin
                    state_nx = last_coin ? ST_DONE : ST_GAP;
                end
`ifdef VEND_DISPENSE_TIMEOUT_EN
                else if (tmr_zero) begin
                    state_nx = ST_DONE;
                end
`endif
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        drink_out = DRK_NONE;
        coin_req  = 1'b0;
        coin_type = COIN5;
        done      = 1'b0;
        case (state_q)
            ST_DRINK: begin
                busy      = 1'b1;
                drink_out = sel_q;
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            ST_COIN_REQ: begin
                busy      = 1'b1;
                coin_req  = 1'b1;
                coin_type = (n10_q != '0) ? COIN10 : COIN5;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= DRK_NONE;
            n10_q <= '0;
            n5_q  <= 1'b0;
        end else if (accept) begin
            sel_q <= drink_sel;
            n10_q <= change_amt[CHG_W-1:1];
            n5_q  <= change_amt[0];
        end else if (coin_taken) begin
            if (n10_q != '0) begin
                n10_q <= n10_q - N10_W'(1);
            end else begin
                n5_q <= 1'b0;
            end
        end
`ifdef VEND_DISPENSE_TIMEOUT_EN
        else if (timed_out) begin
            n10_q <= '0;
            n5_q  <= 1'b0;
        end
`endif
    end

    // One shared timer, reloaded on every state change with that state's dwell minus one.
    assign tmr_load = (state_nx != state_q);

    always_comb begin
        tmr_val = '0;
        case (state_nx)
            ST_DRINK:    tmr_val = TMR_W'(PULSE_W - 1);
            ST_GAP:      tmr_val = TMR_W'(GAP_CYC - 1);
`ifdef VEND_DISPENSE_TIMEOUT_EN
            ST_COIN_REQ: tmr_val = TMR_W'(TIMEOUT_CYC - 1);
`endif
            default:     tmr_val = '0;
        endcase
    end

    vend_pulse_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed per-cycle vector bench for vend_dispense_ctrl (PULSE_W=4, GAP_CYC=2, TIMEOUT_CYC=8).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_vend_dispense_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] drink_sel;
    logic [2:0] change_amt;
    logic       busy;
    logic [1:0] drink_out;
    logic       coin_req;
    logic       coin_type;
    logic       coin_ack;
    logic       done;
    logic       err;

    typedef struct {
        logic       r;
        logic [1:0] s;
        logic [2:0] c;
        logic       a;
        logic [1:0] d;
        logic       b;
        logic       cr;
        logic       ct;
        logic       dn;
        logic       e;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    vend_dispense_ctrl #(
        .CHG_W       (3),
        .PULSE_W     (4),
        .GAP_CYC     (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .drink_sel  (drink_sel),
        .change_amt (change_amt),
        .busy       (busy),
        .drink_out  (drink_out),
        .coin_req   (coin_req),
        .coin_type  (coin_type),
        .coin_ack   (coin_ack),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},      8'(busy),      8'd0);
        chk({tag, ".drink_out"}, 8'(drink_out), 8'd0);
        chk({tag, ".coin_req"},  8'(coin_req),  8'd0);
        chk({tag, ".coin_type"}, 8'(coin_type), 8'd0);
        chk({tag, ".done"},      8'(done),      8'd0);
        chk({tag, ".err"},       8'(err),       8'd0);
    endtask

    // n cycles of: req, drink_sel, change_amt, coin_ack | expected drink_out, busy, coin_req, coin_type, done, err
    task automatic add(input int n, input logic r, input logic [1:0] s, input logic [2:0] c,
                       input logic a, input logic [1:0] d, input logic b, input logic cr,
                       input logic ct, input logic dn, input logic e);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.a = a;
        v.d = d; v.b = b; v.cr = cr; v.ct = ct; v.dn = dn; v.e = e;
        repeat (n) vq.push_back(v);
    endtask

    task automatic run(input string tag);
        foreach (vq[i]) begin
            req        = vq[i].r;
            drink_sel  = vq[i].s;
            change_amt = vq[i].c;
            coin_ack   = vq[i].a;
            @(negedge clk);
            chk($sformatf("%s[%0d].drink_out", tag, i), 8'(drink_out), 8'(vq[i].d));
            chk($sformatf("%s[%0d].busy", tag, i),      8'(busy),      8'(vq[i].b));
            chk($sformatf("%s[%0d].coin_req", tag, i),  8'(coin_req),  8'(vq[i].cr));
            chk($sformatf("%s[%0d].coin_type", tag, i), 8'(coin_type), 8'(vq[i].ct));
            chk($sformatf("%s[%0d].done", tag, i),      8'(done),      8'(vq[i].dn));
            chk($sformatf("%s[%0d].err", tag, i),       8'(err),       8'(vq[i].e));
            @(posedge clk);
            #1;
        end
        req      = 1'b0;
        coin_ack = 1'b0;
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req        = 1'b0;
        drink_sel  = 2'd0;
        change_amt = 3'd0;
        coin_ack   = 1'b0;
        #3;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Drink only: 4-cycle pulse, done in the 6th cycle counting the req cycle; later input churn ignored.
        add(1, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0);
        add(4, 0, 0, 5, 1,  2, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("drk");

        // Drink 1 with change 3: one 10-coin then one 5-coin, acks on the third request cycle.
        add(1, 1, 1, 3, 0,  0, 0, 0, 0, 0, 0);
        add(4, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("mix");

        // Second req during DRINK is dropped: one pulse of code 1, one done, then idle.
        add(1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
        add(1, 1, 2, 3, 0,  1, 1, 0, 0, 0, 0);
        add(2, 0, 2, 3, 0,  1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("bsy");

        // Empty order completes on the cycle after acceptance.
        add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("zero");

        // Reserved code 3 with no change behaves as an empty order.
        add(1, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("rsv");

        // Change 3, no drink: acks in GAP are ignored, first coin held 50 cycles, second acked at once.
        add(1, 1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
        add(50, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("late");

        // Maximum change 7: three 10-coins then one 5-coin at the minimum coin period.
        add(1, 1, 0, 7, 0,  0, 0, 0, 0, 0, 0);
        repeat (3) begin
            add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
            add(1, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0);
        end
        add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("max");

        // Reset asserted mid-cycle while a 10-coin request is outstanding.
        add(1, 1, 0, 2, 0,  0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0);
        run("rst_a");
        #2;
        chk("rst_pre.coin_req", 8'(coin_req), 8'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        @(posedge clk);
        #2;
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add(1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("rst_b");

`ifdef VEND_DISPENSE_TIMEOUT_EN
        // No ack for 8 request cycles: err set with done; cleared by the next accepted order.
        add(1, 1, 0, 2, 0,  0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(8, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        run("tmo");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
